// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared widths, rounding modes, skid states and entry layout for the FPU operand unpack stage (FPU_UNPACK_FCLASS_EN adds fclass fields)
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;

  // First resolved rounding value that no longer names a real mode
  localparam logic [2:0] RM_FIRST_ILLEGAL = 3'b101;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic              sign_a;
    logic [EXP_W-1:0]  exp_a;
    logic [FRAC_W-1:0] sig_a;
    logic              is_zero_a;
    logic              is_inf_a;
    logic              is_nan_a;
    logic              is_subnorm_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_b;
    logic [FRAC_W-1:0] sig_b;
    logic              is_zero_b;
    logic              is_inf_b;
    logic              is_nan_b;
    logic              is_subnorm_b;
    logic              is_signaling;
    logic              sub_op;
    logic [2:0]        rm;
    logic              illegal_rm;
`ifdef FPU_UNPACK_FCLASS_EN
    logic [9:0]        fclass_a;
    logic [9:0]        fclass_b;
`endif
  } unpack_entry_t;

  localparam int ENTRY_W = $bits(unpack_entry_t);

endpackage

// File: rtl/fpu_classify.sv
// rtl/fpu_classify.sv - combinational field split and class decode of one single-precision operand (FPU_UNPACK_FCLASS_EN adds fclass)
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [FRAC_W-1:0] frac_o,
  output logic              is_zero_o,
  output logic              is_inf_o,
  output logic              is_nan_o,
  output logic              is_subnorm_o,
`ifdef FPU_UNPACK_FCLASS_EN
  output logic [9:0]        fclass_o,
`endif
  output logic              is_snan_o
);

  logic exp_zero;
  logic exp_max;
  logic frac_zero;

  assign sign_o = op_i[31];
  assign exp_o  = op_i[30:23];
  assign frac_o = op_i[22:0];

  assign exp_zero  = (exp_o == '0);
  assign exp_max   = (exp_o == EXP_MAX);
  assign frac_zero = (frac_o == '0);

  assign is_zero_o    = exp_zero & frac_zero;
  assign is_subnorm_o = exp_zero & ~frac_zero;
  assign is_inf_o     = exp_max & frac_zero;
  assign is_nan_o     = exp_max & ~frac_zero;
  // Quiet bit is the fraction MSB; a NaN with it clear is signaling
  assign is_snan_o    = is_nan_o & ~frac_o[FRAC_W-1];

`ifdef FPU_UNPACK_FCLASS_EN
  logic is_normal;
  assign is_normal = ~exp_zero & ~exp_max;

  // One-hot FCLASS.S encoding: negatives in bits 0..3, positives in 4..7, NaNs in 8..9
  always_comb begin
    fclass_o    = '0;
    fclass_o[0] = sign_o & is_inf_o;
    fclass_o[1] = sign_o & is_normal;
    fclass_o[2] = sign_o & is_subnorm_o;
    fclass_o[3] = sign_o & is_zero_o;
    fclass_o[4] = ~sign_o & is_zero_o;
    fclass_o[5] = ~sign_o & is_subnorm_o;
    fclass_o[6] = ~sign_o & is_normal;
    fclass_o[7] = ~sign_o & is_inf_o;
    fclass_o[8] = is_snan_o;
    fclass_o[9] = is_nan_o & frac_o[FRAC_W-1];
  end
`endif

endmodule

// File: rtl/fpu_operand_unpack.sv
// rtl/fpu_operand_unpack.sv - registered add/sub operand unpack stage with 2-entry skid buffer (FPU_UNPACK_FCLASS_EN adds fclass outputs)
module fpu_operand_unpack
  import fpu_pkg::*;
#(
  parameter logic [2:0] RM_DYN = DYN
)
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       op_a_i,
  input  logic [31:0]       op_b_i,
  input  logic              sub_op_i,
  input  logic [2:0]        rm_i,
  input  logic [2:0]        frm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sign_a_o,
  output logic              sign_b_o,
  output logic [EXP_W-1:0]  exp_a_o,
  output logic [EXP_W-1:0]  exp_b_o,
  output logic [FRAC_W-1:0] sig_a_o,
  output logic [FRAC_W-1:0] sig_b_o,
  output logic              is_zero_a_o,
  output logic              is_zero_b_o,
  output logic              is_inf_a_o,
  output logic              is_inf_b_o,
  output logic              is_nan_a_o,
  output logic              is_nan_b_o,
  output logic              is_subnorm_a_o,
  output logic              is_subnorm_b_o,
`ifdef FPU_UNPACK_FCLASS_EN
  output logic [9:0]        fclass_a_o,
  output logic [9:0]        fclass_b_o,
`endif
  output logic              is_signaling_o,
  output logic              sub_op_o,
  output logic [2:0]        rm_o,
  output logic              illegal_rm_o
);

  unpack_entry_t in_entry;
  unpack_entry_t main_q;
  unpack_entry_t skid_q;
  skid_state_t   state_q;
  skid_state_t   state_d;
  logic          in_ready_q;
  logic          accept;
  logic          fire;
  logic          load_main_in;
  logic          load_main_skid;
  logic          load_skid;
  logic [2:0]    rm_res;

  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sub_a, sub_b;
  logic              snan_a, snan_b;
`ifdef FPU_UNPACK_FCLASS_EN
  logic [9:0]        fclass_a, fclass_b;
`endif

  fpu_classify u_cls_a (
    .op_i         (op_a_i),
    .sign_o       (sign_a),
    .exp_o        (exp_a),
    .frac_o       (frac_a),
    .is_zero_o    (zero_a),
    .is_inf_o     (inf_a),
    .is_nan_o     (nan_a),
    .is_subnorm_o (sub_a),
`ifdef FPU_UNPACK_FCLASS_EN
    .fclass_o     (fclass_a),
`endif
    .is_snan_o    (snan_a)
  );

  fpu_classify u_cls_b (
    .op_i         (op_b_i),
    .sign_o       (sign_b),
    .exp_o        (exp_b),
    .frac_o       (frac_b),
    .is_zero_o    (zero_b),
    .is_inf_o     (inf_b),
    .is_nan_o     (nan_b),
    .is_subnorm_o (sub_b),
`ifdef FPU_UNPACK_FCLASS_EN
    .fclass_o     (fclass_b),
`endif
    .is_snan_o    (snan_b)
  );

  // Illegal modes still travel with the entry; the trap is raised downstream
  assign rm_res = (rm_i == RM_DYN) ? frm_i : rm_i;

  // Assemble the entry that is captured on accept
  always_comb begin
    in_entry              = '0;
    in_entry.sign_a       = sign_a;
    in_entry.exp_a        = exp_a;
    in_entry.sig_a        = frac_a;
    in_entry.is_zero_a    = zero_a;
    in_entry.is_inf_a     = inf_a;
    in_entry.is_nan_a     = nan_a;
    in_entry.is_subnorm_a = sub_a;
    in_entry.sign_b       = sign_b;
    in_entry.exp_b        = exp_b;
    in_entry.sig_b        = frac_b;
    in_entry.is_zero_b    = zero_b;
    in_entry.is_inf_b     = inf_b;
    in_entry.is_nan_b     = nan_b;
    in_entry.is_subnorm_b = sub_b;
    in_entry.is_signaling = snan_a | snan_b;
    in_entry.sub_op       = sub_op_i;
    in_entry.rm           = rm_res;
    in_entry.illegal_rm   = (rm_res >= RM_FIRST_ILLEGAL);
`ifdef FPU_UNPACK_FCLASS_EN
    in_entry.fclass_a     = fclass_a;
    in_entry.fclass_b     = fclass_b;
`endif
  end

  assign accept = in_valid_i & in_ready_q;
  assign fire   = out_valid_o & out_ready_i;

  // Skid state and the registered ready that is derived from the next state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  // Occupancy transitions; flush wins and drops any same-cycle accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !fire)      state_d = S_TWO;
        else if (!accept && fire) state_d = S_EMPTY;
      end
      S_TWO:   if (fire) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) state_d = S_EMPTY;
  end

  // Handshake outputs and data-register load strobes decoded from the state
  always_comb begin
    out_valid_o    = (state_q != S_EMPTY);
    load_main_in   = accept & ((state_q == S_EMPTY) | ((state_q == S_ONE) & fire));
    load_skid      = accept & (state_q == S_ONE) & ~fire;
    load_main_skid = (state_q == S_TWO) & fire;
  end

  assign in_ready_o = in_ready_q;

  // Main and skid entry storage; contents may go stale after flush
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  assign sign_a_o       = main_q.sign_a;
  assign exp_a_o        = main_q.exp_a;
  assign sig_a_o        = main_q.sig_a;
  assign is_zero_a_o    = main_q.is_zero_a;
  assign is_inf_a_o     = main_q.is_inf_a;
  assign is_nan_a_o     = main_q.is_nan_a;
  assign is_subnorm_a_o = main_q.is_subnorm_a;
  assign sign_b_o       = main_q.sign_b;
  assign exp_b_o        = main_q.exp_b;
  assign sig_b_o        = main_q.sig_b;
  assign is_zero_b_o    = main_q.is_zero_b;
  assign is_inf_b_o     = main_q.is_inf_b;
  assign is_nan_b_o     = main_q.is_nan_b;
  assign is_subnorm_b_o = main_q.is_subnorm_b;
  assign is_signaling_o = main_q.is_signaling;
  assign sub_op_o       = main_q.sub_op;
  assign rm_o           = main_q.rm;
  assign illegal_rm_o   = main_q.illegal_rm;
`ifdef FPU_UNPACK_FCLASS_EN
  assign fclass_a_o     = main_q.fclass_a;
  assign fclass_b_o     = main_q.fclass_b;
`endif

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// tb/tb_fpu_operand_unpack.sv - randomized and directed bench for fpu_operand_unpack against a queue-based reference model (FPU_UNPACK_FCLASS_EN aware)
module tb_fpu_operand_unpack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sub_op = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [2:0]  rm = '0;
  logic [2:0]  frm = '0;

  logic        in_ready_o, out_valid_o;
  logic        sign_a_o, sign_b_o;
  logic [7:0]  exp_a_o, exp_b_o;
  logic [22:0] sig_a_o, sig_b_o;
  logic        is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o;
  logic        is_nan_a_o, is_nan_b_o, is_subnorm_a_o, is_subnorm_b_o;
  logic        is_signaling_o, sub_op_o, illegal_rm_o;
  logic [2:0]  rm_o;
`ifdef FPU_UNPACK_FCLASS_EN
  logic [9:0]  fclass_a_o, fclass_b_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] raw_a;
    logic [3:0]  flg_a;
    logic [31:0] raw_b;
    logic [3:0]  flg_b;
    logic [5:0]  misc;
    logic [19:0] fcl;
  } exp_t;

  exp_t model_q[$];

  fpu_operand_unpack dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready_o),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .sub_op_i       (sub_op),
    .rm_i           (rm),
    .frm_i          (frm),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready),
    .sign_a_o       (sign_a_o),
    .sign_b_o       (sign_b_o),
    .exp_a_o        (exp_a_o),
    .exp_b_o        (exp_b_o),
    .sig_a_o        (sig_a_o),
    .sig_b_o        (sig_b_o),
    .is_zero_a_o    (is_zero_a_o),
    .is_zero_b_o    (is_zero_b_o),
    .is_inf_a_o     (is_inf_a_o),
    .is_inf_b_o     (is_inf_b_o),
    .is_nan_a_o     (is_nan_a_o),
    .is_nan_b_o     (is_nan_b_o),
    .is_subnorm_a_o (is_subnorm_a_o),
    .is_subnorm_b_o (is_subnorm_b_o),
`ifdef FPU_UNPACK_FCLASS_EN
    .fclass_a_o     (fclass_a_o),
    .fclass_b_o     (fclass_b_o),
`endif
    .is_signaling_o (is_signaling_o),
    .sub_op_o       (sub_op_o),
    .rm_o           (rm_o),
    .illegal_rm_o   (illegal_rm_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Category index 0..9 in FCLASS order, from plain exponent/fraction arithmetic
  function automatic int class_idx(input logic [31:0] x);
    int e = int'(x >> 23) & 255;
    int f = int'(x & 32'h007F_FFFF);
    bit neg = x[31];
    if (e == 255 && f != 0) return (f >= 32'h0040_0000) ? 9 : 8;
    if (e == 255) return neg ? 0 : 7;
    if (e == 0 && f == 0) return neg ? 3 : 4;
    if (e == 0) return neg ? 2 : 5;
    return neg ? 1 : 6;
  endfunction

  // {zero, inf, nan, subnormal}
  function automatic logic [3:0] flags_of(input logic [31:0] x);
    case (class_idx(x))
      3, 4:    return 4'b1000;
      0, 7:    return 4'b0100;
      8, 9:    return 4'b0010;
      2, 5:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [2:0] r, input logic [2:0] fr);
    exp_t e;
    int   res;
    bit   sig;
    res     = (r == 3'd7) ? int'(fr) : int'(r);
    sig     = (class_idx(a) == 8) || (class_idx(b) == 8);
    e.raw_a = a;
    e.flg_a = flags_of(a);
    e.raw_b = b;
    e.flg_b = flags_of(b);
    e.misc  = {sig, s, 3'(res), (res >= 5)};
    e.fcl   = {10'(1 << class_idx(a)), 10'(1 << class_idx(b))};
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    check("in_ready", 64'(in_ready_o), 64'(model_q.size() < 2));
    check("out_valid", 64'(out_valid_o), 64'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      e = model_q[0];
      check("fields_a", 64'({sign_a_o, exp_a_o, sig_a_o}), 64'(e.raw_a));
      check("flags_a", 64'({is_zero_a_o, is_inf_a_o, is_nan_a_o, is_subnorm_a_o}), 64'(e.flg_a));
      check("fields_b", 64'({sign_b_o, exp_b_o, sig_b_o}), 64'(e.raw_b));
      check("flags_b", 64'({is_zero_b_o, is_inf_b_o, is_nan_b_o, is_subnorm_b_o}), 64'(e.flg_b));
      check("misc", 64'({is_signaling_o, sub_op_o, rm_o, illegal_rm_o}), 64'(e.misc));
`ifdef FPU_UNPACK_FCLASS_EN
      check("fclass", 64'({fclass_a_o, fclass_b_o}), 64'(e.fcl));
`endif
    end
  endtask

  // One clock: check the held state, drive new inputs, advance the model at the edge
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [2:0] r, input logic [2:0] fr,
                      input logic rdy, input logic fl, output logic acc);
    logic fire;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    op_a      = a;
    op_b      = b;
    sub_op    = s;
    rm        = r;
    frm       = fr;
    out_ready = rdy;
    flush     = fl;
    acc  = v && !fl && (model_q.size() < 2);
    fire = rdy && (model_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (fire) void'(model_q.pop_front());
      if (acc) model_q.push_back(model(a, b, s, r, fr));
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [22:0] f;
    logic [7:0]  e;
    f = 23'($urandom);
    if (f == '0) f = 23'd1;
    case ($urandom % 6)
      0:       begin e = 8'd0;   f = '0; end
      1:       begin e = 8'd255; f = '0; end
      2:       e = 8'd255;
      3:       e = 8'd0;
      default: begin e = 8'($urandom); end
    endcase
    return {1'($urandom), e, f};
  endfunction

  logic        acc;
  int          idx;
  logic [31:0] stream_a[4];

  initial begin
    stream_a[0] = 32'h3F80_0000;
    stream_a[1] = 32'h4000_0000;
    stream_a[2] = 32'h0000_0001;
    stream_a[3] = 32'hFF80_0000;

    #12;
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_fields", 64'({sign_a_o, exp_a_o, sig_a_o, is_zero_a_o, is_signaling_o, rm_o, illegal_rm_o}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    step(1, 32'h3F80_0000, 32'h8000_0000, 0, 3'b000, 3'b000, 1, 0, acc);
    #1;
    check("tp_zero_b", 64'({is_zero_b_o, sign_b_o}), 64'b11);
    check("tp_a_flags", 64'({is_zero_a_o, is_inf_a_o, is_nan_a_o, is_subnorm_a_o}), 64'd0);
    check("tp_rm", 64'({rm_o, illegal_rm_o}), 64'd0);
    step(1, 32'h7F80_0001, 32'h7FC0_0000, 1, 3'b000, 3'b000, 1, 0, acc);
    #1;
    check("tp_snan", 64'({is_nan_a_o, is_nan_b_o, is_signaling_o}), 64'b111);
    step(1, 32'h7FC0_0000, 32'h7FC0_0000, 0, 3'b000, 3'b000, 1, 0, acc);
    #1;
    check("tp_qnan", 64'(is_signaling_o), 64'd0);
    step(1, 32'h4040_0000, 32'h0000_0010, 0, 3'b111, 3'b011, 1, 0, acc);
    #1;
    check("tp_dyn_ok", 64'({rm_o, illegal_rm_o}), 64'b0110);
    step(1, 32'h4040_0000, 32'h0000_0010, 0, 3'b111, 3'b110, 1, 0, acc);
    #1;
    check("tp_dyn_bad", 64'({rm_o, illegal_rm_o}), 64'b1101);
    step(1, 32'h4040_0000, 32'h0000_0010, 0, 3'b101, 3'b000, 1, 0, acc);
    #1;
    check("tp_rm101", 64'({rm_o, illegal_rm_o}), 64'b1011);
`ifdef FPU_UNPACK_FCLASS_EN
    step(1, 32'hFF80_0000, 32'h0000_0000, 0, 3'b000, 3'b000, 1, 0, acc);
    #1;
    check("tp_fclass_ninf", 64'(fclass_a_o), 64'd1);
`endif
    step(0, '0, '0, 0, 3'b000, 3'b000, 1, 0, acc);

    // Four back-to-back requests held until accepted, consumer stalled 3 cycles
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(idx < 4, stream_a[idx % 4], 32'(idx), 0, 3'b001, 3'b000, cyc >= 3, 0, acc);
      if (acc) idx++;
      if (cyc == 1) begin
        #1;
        check("stream_full", 64'(in_ready_o), 64'd0);
      end
    end
    check("stream_all_sent", 64'(idx), 64'd4);

    // Fill to TWO, then flush with a simultaneous request
    step(1, 32'h1111_1111, 32'h2222_2222, 0, 3'b000, 3'b000, 0, 0, acc);
    step(1, 32'h3333_3333, 32'h4444_4444, 0, 3'b000, 3'b000, 0, 0, acc);
    step(1, 32'h5555_5555, 32'h6666_6666, 0, 3'b000, 3'b000, 0, 1, acc);
    #1;
    check("flush_valid", 64'(out_valid_o), 64'd0);
    check("flush_ready", 64'(in_ready_o), 64'd1);
    step(0, '0, '0, 0, 3'b000, 3'b000, 1, 0, acc);
    step(0, '0, '0, 0, 3'b000, 3'b000, 1, 0, acc);

    // Asynchronous reset between clock edges with entries in flight
    step(1, 32'h3F80_0000, 32'h3F80_0000, 0, 3'b000, 3'b000, 0, 0, acc);
    step(1, 32'h4080_0000, 32'h3F80_0000, 0, 3'b000, 3'b000, 0, 0, acc);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", 64'(out_valid_o), 64'd0);
    check("areset_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();

    // Random traffic, random back-pressure and occasional flush
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 10) < 7, rand_op(), rand_op(), 1'($urandom), 3'($urandom), 3'($urandom),
           ($urandom % 10) < 6, ($urandom % 40) == 0, acc);
    end
    for (int i = 0; i < 3; i++) step(0, '0, '0, 0, 3'b000, 3'b000, 1, 0, acc);
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_operand_unpack.md
Name: fpu_operand_unpack

Overview:
- Front-end stage of the FPU add/sub path. Accepts two raw IEEE-754 single-precision operands, an add/sub op bit and an instruction rounding field.
- Produces the unpacked fields, class flags, sNaN indication and resolved rounding mode consumed by the add/sub special-case (fast-path) logic and the main datapath.
- One registered stage behind a valid/ready handshake with a 2-entry skid buffer: full throughput, 1-cycle latency.

Parameters:
- RM_DYN, 3'b111, instruction rounding-field encoding that selects the dynamic mode from frm_i.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous kill of all held entries
- in_valid_i  in  1  input request valid
- in_ready_o  out  1  stage can accept
- op_a_i  in  32  raw operand A
- op_b_i  in  32  raw operand B
- sub_op_i  in  1  1 = subtract
- rm_i  in  3  instruction rounding field
- frm_i  in  3  CSR dynamic rounding mode
- out_valid_o  out  1  unpacked entry valid
- out_ready_i  in  1  consumer accepts
- sign_a_o, sign_b_o  out  1 each  operand signs
- exp_a_o, exp_b_o  out  8 each  biased exponents
- sig_a_o, sig_b_o  out  23 each  fraction fields
- is_zero_a_o, is_zero_b_o  out  1 each  exp==0 and frac==0
- is_inf_a_o, is_inf_b_o  out  1 each  exp==255 and frac==0
- is_nan_a_o, is_nan_b_o  out  1 each  exp==255 and frac!=0
- is_subnorm_a_o, is_subnorm_b_o  out  1 each  exp==0 and frac!=0
- is_signaling_o  out  1  either operand is sNaN (NaN with frac[22]==0)
- sub_op_o  out  1  registered sub_op_i
- rm_o  out  3  resolved rounding mode
- illegal_rm_o  out  1  resolved mode is 101, 110 or 111

Behaviour:
- Reset: all outputs 0 except in_ready_o=1. Skid state is EMPTY. Reset asserted mid-operation discards all entries immediately.
- Classification is combinational on the input side and captured at accept. Flags are mutually exclusive per operand; a normal number has all four flags 0.
- rm_o = (rm_i==RM_DYN) ? frm_i : rm_i. illegal_rm_o is set when the resolved value is >=3'b101. The entry still propagates; the downstream stage raises the trap.
- Accept when in_valid_i & in_ready_o. Fire when out_valid_o & out_ready_i.
- Skid FSM has three states: EMPTY, ONE (main register valid), TWO (main and skid registers valid).
  - EMPTY: accept -> ONE. Data goes to main; out_valid_o=1 the next cycle.
  - ONE, accept and fire -> ONE, main loaded with the new data.
  - ONE, accept only -> TWO, new data goes to skid.
  - ONE, fire only -> EMPTY.
  - TWO: fire -> ONE, skid moves to main. No accept is possible in TWO.
- in_ready_o is registered: it is 1 in EMPTY and ONE, and 0 in TWO.
- Output fields come from the main register only. They are held stable while out_valid_o=1 and out_ready_i=0.
- flush_i takes priority over everything: next state EMPTY, and a same-cycle accept is dropped. Output data may keep stale values; out_valid_o goes to 0.
- Ordering is strictly FIFO. No entry is lost or duplicated under any valid/ready pattern.

Optional Feature:
- Macro: FPU_UNPACK_FCLASS_EN.
- Defined: adds output ports fclass_a_o and fclass_b_o, 10 bits each, in RISC-V FCLASS.S bit order (bit0 -inf ... bit9 qNaN). They are computed at accept and registered and skidded with the entry.
- Undefined: these ports do not exist and no fclass logic is built. All other behaviour is identical.

Decomposition:
- Package fpu_pkg holds:
  - exponent/fraction width constants (8, 23) and EXP_MAX=255;
  - rounding-mode localparams RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111;
  - the packed entry width constant.
- One sub-module, fpu_classify: purely combinational, one 32-bit operand in, fields/flags/fclass out. It is instantiated twice.

Test Plan:
- op_a=0x3F800000, op_b=0x80000000, rm=000, out_ready=1 -> one cycle later: is_zero_b=1, sign_b=1, all A flags 0, rm_o=000, illegal_rm_o=0.
- op_a=0x7F800001, op_b=0x7FC00000 -> is_nan_a=is_nan_b=1, is_signaling_o=1. Repeat with op_a=0x7FC00000 -> is_signaling_o=0.
- rm_i=111 with frm_i=011 -> rm_o=011, illegal_rm_o=0. rm_i=111 with frm_i=110 -> illegal_rm_o=1. rm_i=101 -> illegal_rm_o=1.
- Stream of 4 back-to-back inputs with out_ready=0 for 3 cycles:
  - after 2 accepts in_ready_o=0;
  - outputs stay stable on entry 0;
  - after release, entries 0..3 emerge in order with no gaps.
- State TWO, assert flush_i together with in_valid_i -> next cycle out_valid_o=0 and in_ready_o=1, and the flushed input never appears.
- Assert reset_i asynchronously mid-stream -> out_valid_o=0 and in_ready_o=1 without waiting for a clock edge. With the macro defined, op_a=0xFF800000 gives fclass_a_o=10'b0000000001.
